// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU run sequencer: FSM state encoding,
// memory byte strides and the word-index to byte-address helper.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLR      = 3'd1,
    ST_LOAD_I   = 3'd2,
    ST_LOAD_D   = 3'd3,
    ST_RUN      = 3'd4,
    ST_DUMP_RD  = 3'd5,
    ST_DUMP_OUT = 3'd6,
    ST_DONE     = 3'd7
  } seq_state_t;

  // Instruction memory holds 32-bit words, data memory 64-bit words.
  localparam logic [63:0] IMEM_STRIDE = 64'd4;
  localparam logic [63:0] DMEM_STRIDE = 64'd8;

  // Word counter width (covers 0..1024) and run-cycle counter width.
  localparam int K_W = 11;
  localparam int C_W = 32;

  function automatic logic [63:0] byte_addr(input logic [K_W-1:0] idx,
                                            input logic [63:0]    stride);
    return {{(64-K_W){1'b0}}, idx} * stride;
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Loadable, clearable up-counter with a terminal-count compare.
// Priority: reset, then clear, then load, then increment.
module seq_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] r_count;

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (inc) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;
  assign tc    = (r_count == term);

endmodule

// File: rtl/cpu_run_sequencer.sv
// Host-side run sequencer for the cpu top: loads instruction and data
// images through the external memory ports, pulses the CPU reset, enables
// the CPU for a programmed number of cycles, then streams data memory back.
module cpu_run_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic [9:0]  imem_len,
  input  logic [10:0] dmem_len,
  input  logic [31:0] run_cycles,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        cpu_rst_n,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        busy,
  output logic        done
);

  localparam logic [K_W-1:0] IMEM_LIM = K_W'(IMEM_WORDS);
  localparam logic [K_W-1:0] DMEM_LIM = K_W'(DMEM_WORDS);

  // Requested lengths beyond the memory depth are clamped to the depth.
  function automatic logic [K_W-1:0] sat_len(input logic [K_W-1:0] len,
                                             input logic [K_W-1:0] lim);
    return (len > lim) ? lim : len;
  endfunction

  seq_state_t r_state;
  seq_state_t w_next;
  seq_state_t w_after_clr;
  seq_state_t w_after_i;
  seq_state_t w_after_d;
  seq_state_t w_after_run;

  logic [K_W-1:0] r_ilen;
  logic [K_W-1:0] r_dlen;
  logic [C_W-1:0] r_rcyc;
  logic [63:0]    r_out_data;

  logic [K_W-1:0] w_k;
  logic [K_W-1:0] w_k_term;
  logic           w_k_tc;
  logic           w_k_clr;
  logic           w_k_inc;

  logic [C_W-1:0] w_c;
  logic [C_W-1:0] w_c_term;
  logic           w_c_tc;
  logic           w_c_clr;
  logic           w_c_inc;
  logic           w_unused_c;

  // k indexes words in the load and dump phases; c counts enabled cycles.
  seq_counter #(.W(K_W)) u_k_cnt (
    .clk      (clk),
    .arst_n   (arst_n),
    .clr      (w_k_clr),
    .load     (1'b0),
    .load_val ({K_W{1'b0}}),
    .inc      (w_k_inc),
    .term     (w_k_term),
    .count    (w_k),
    .tc       (w_k_tc)
  );

  seq_counter #(.W(C_W)) u_c_cnt (
    .clk      (clk),
    .arst_n   (arst_n),
    .clr      (w_c_clr),
    .load     (1'b0),
    .load_val ({C_W{1'b0}}),
    .inc      (w_c_inc),
    .term     (w_c_term),
    .count    (w_c),
    .tc       (w_c_tc)
  );

  // The run counter value itself is only consumed through its compare.
  assign w_unused_c = ^w_c;

  // Terminal word index depends on which stream phase is active.
  assign w_k_term = (r_state == ST_LOAD_I) ? (r_ilen - 11'd1) : (r_dlen - 11'd1);
  assign w_c_term = r_rcyc - 32'd1;

  // Empty phases are skipped by chaining forward to the next non-empty one.
  assign w_after_run = (r_dlen != '0) ? ST_DUMP_RD : ST_DONE;
  assign w_after_d   = (r_rcyc != '0) ? ST_RUN     : w_after_run;
  assign w_after_i   = (r_dlen != '0) ? ST_LOAD_D  : w_after_d;
  assign w_after_clr = (r_ilen != '0) ? ST_LOAD_I  : w_after_i;

  // State register.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the run parameters when a start is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_ilen <= '0;
      r_dlen <= '0;
      r_rcyc <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_ilen <= sat_len({1'b0, imem_len}, IMEM_LIM);
      r_dlen <= sat_len(dmem_len, DMEM_LIM);
      r_rcyc <= run_cycles;
    end
  end

  // Dump word is sampled from data memory at the end of the read cycle and
  // held until the host accepts it; it is only visible while out_valid.
  always_ff @(posedge clk) begin
    if (r_state == ST_DUMP_RD) begin
      r_out_data <= rdata_ext_2;
    end
  end

  // Next-state, counter control and output decode.
  always_comb begin
    w_next      = r_state;
    w_k_clr     = 1'b0;
    w_k_inc     = 1'b0;
    w_c_clr     = 1'b1;
    w_c_inc     = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = 64'd0;
    cpu_rst_n   = 1'b1;
    cpu_enable  = 1'b0;
    addr_ext    = 64'd0;
    wen_ext     = 1'b0;
    ren_ext     = 1'b0;
    wdata_ext   = 32'd0;
    addr_ext_2  = 64'd0;
    wen_ext_2   = 1'b0;
    ren_ext_2   = 1'b0;
    wdata_ext_2 = 64'd0;
    busy        = 1'b1;
    done        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_k_clr = 1'b1;
          w_next  = ST_CLR;
        end
      end

      ST_CLR: begin
        cpu_rst_n = 1'b0;
        w_next    = w_after_clr;
      end

      ST_LOAD_I: begin
        in_ready = 1'b1;
        wen_ext  = in_valid;
        if (in_valid) begin
          addr_ext  = byte_addr(w_k, IMEM_STRIDE);
          wdata_ext = in_data[31:0];
          if (w_k_tc) begin
            w_k_clr = 1'b1;
            w_next  = w_after_i;
          end else begin
            w_k_inc = 1'b1;
          end
        end
      end

      ST_LOAD_D: begin
        in_ready  = 1'b1;
        wen_ext_2 = in_valid;
        if (in_valid) begin
          addr_ext_2  = byte_addr(w_k, DMEM_STRIDE);
          wdata_ext_2 = in_data;
          if (w_k_tc) begin
            w_k_clr = 1'b1;
            w_next  = w_after_d;
          end else begin
            w_k_inc = 1'b1;
          end
        end
      end

      ST_RUN: begin
        cpu_enable = 1'b1;
        w_c_clr    = 1'b0;
        if (w_c_tc) begin
          w_next = w_after_run;
        end else begin
          w_c_inc = 1'b1;
        end
      end

      ST_DUMP_RD: begin
        ren_ext_2  = 1'b1;
        addr_ext_2 = byte_addr(w_k, DMEM_STRIDE);
        w_next     = ST_DUMP_OUT;
      end

      ST_DUMP_OUT: begin
        out_valid = 1'b1;
        out_data  = r_out_data;
        if (out_ready) begin
          if (w_k_tc) begin
            w_k_clr = 1'b1;
            w_next  = ST_DONE;
          end else begin
            w_k_inc = 1'b1;
            w_next  = ST_DUMP_RD;
          end
        end
      end

      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end

      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Self-checking bench for cpu_run_sequencer: a data-memory model on the
// external port, table-driven runs with hand-computed expectations, a few
// multi-cycle corner sequences, and randomized runs against a reference
// built from the stream contents.
module tb_cpu_run_sequencer;

  localparam int IW = 512;
  localparam int DW = 1024;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start;
  logic [9:0]  imem_len;
  logic [10:0] dmem_len;
  logic [31:0] run_cycles;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        cpu_rst_n;
  logic        cpu_enable;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  cpu_run_sequencer #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .start       (start),
    .imem_len    (imem_len),
    .dmem_len    (dmem_len),
    .run_cycles  (run_cycles),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .cpu_rst_n   (cpu_rst_n),
    .cpu_enable  (cpu_enable),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2),
    .busy        (busy),
    .done        (done)
  );

  // Data memory model: combinational read, write on the clock edge.
  logic [63:0] dmem [DW];
  logic        pf_req;
  logic [31:0] pf_seed;

  always @(posedge clk) begin
    if (pf_req) begin
      for (int i = 0; i < DW; i++) dmem[i] <= {pf_seed, 32'(i)};
    end else if (wen_ext_2) begin
      dmem[addr_ext_2[12:3]] <= wdata_ext_2;
    end
  end

  assign rdata_ext_2 = ren_ext_2 ? dmem[addr_ext_2[12:3]] : 64'd0;

  // Scoreboard state.
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
  } wr_t;

  logic [63:0] strm[$];
  logic [63:0] got_dump[$];
  wr_t         got_iw[$];
  wr_t         got_dw[$];
  logic [63:0] ref_d [DW];

  int   sidx, cyc, n_en, en_rises, n_busy, n_done, viol;
  int   first_rdy, last_hs, first_en, stall_cnt;
  logic prev_en, prev_stall;
  logic [63:0] prev_od;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Inputs for the current cycle; reads only registered-state outputs.
  task automatic drive_inputs(input int vm, input int rm, input bit spam);
    start = spam ? busy : 1'b0;
    case (vm)
      0:       in_valid = 1'b1;
      1:       in_valid = (cyc % 2 == 0);
      default: in_valid = 1'($urandom_range(0, 1));
    endcase
    if (sidx >= strm.size()) in_valid = 1'b0;
    in_data = in_valid ? strm[sidx] : {$urandom, $urandom};
    case (rm)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid) stall_cnt++;
        out_ready = out_valid && (stall_cnt > 7);
      end
    endcase
  endtask

  // Observe one settled cycle and record what the coming edge commits.
  task automatic sample();
    if (busy) n_busy++;
    if (done) n_done++;
    if (cpu_enable) begin
      n_en++;
      if (!prev_en) begin
        en_rises++;
        first_en = cyc;
      end
    end
    prev_en = cpu_enable;
    if (in_ready && first_rdy < 0) first_rdy = cyc;
    if (in_valid && in_ready) begin
      sidx++;
      last_hs = cyc;
    end
    if (wen_ext) begin
      got_iw.push_back('{addr_ext, {32'd0, wdata_ext}});
      if (!in_valid) viol++;
    end
    if (wen_ext_2) begin
      got_dw.push_back('{addr_ext_2, wdata_ext_2});
      if (!in_valid) viol++;
    end
    if ((wen_ext || ren_ext) && (wen_ext_2 || ren_ext_2)) viol++;
    if (!wen_ext && !ren_ext && (addr_ext != 64'd0 || wdata_ext != 32'd0)) viol++;
    if (!wen_ext_2 && !ren_ext_2 && addr_ext_2 != 64'd0) viol++;
    if (!wen_ext_2 && wdata_ext_2 != 64'd0) viol++;
    if (!out_valid && out_data != 64'd0) viol++;
    if (prev_stall && (!out_valid || out_data !== prev_od || ren_ext_2)) viol++;
    prev_stall = out_valid && !out_ready;
    prev_od    = out_data;
    if (out_valid && out_ready) begin
      got_dump.push_back(out_data);
      stall_cnt = 0;
    end
  endtask

  task automatic do_run(input string tag, input int il, input int dl, input int rc,
                        input int vm, input int rm, input bit spam,
                        input int ei, input int ed, input int exp_busy);
    bit fin;
    int idle_busy;
    @(negedge clk);
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pf_seed   = $urandom;
    pf_req    = 1'b1;
    @(negedge clk);
    pf_req = 1'b0;
    for (int i = 0; i < DW; i++) ref_d[i] = {pf_seed, 32'(i)};
    strm.delete();
    for (int i = 0; i < ei + ed; i++) strm.push_back({$urandom, $urandom});
    got_iw.delete();
    got_dw.delete();
    got_dump.delete();
    sidx = 0; n_en = 0; en_rises = 0; n_busy = 0; n_done = 0; viol = 0;
    first_rdy = -1; last_hs = -1; first_en = -1; stall_cnt = 0;
    prev_en = 1'b0; prev_stall = 1'b0; prev_od = 64'd0; fin = 1'b0;
    imem_len   = 10'(il);
    dmem_len   = 11'(dl);
    run_cycles = 32'(rc);
    start      = 1'b1;
    cyc        = 0;
    while (!fin && cyc < 20000) begin
      if (cyc > 0) begin
        @(negedge clk);
        drive_inputs(vm, rm, spam);
      end
      #1;
      sample();
      if (done) fin = 1'b1;
      cyc++;
    end
    chk({tag, " finished"}, 64'(fin), 64'd1);

    // Reference: stream word i goes to imem word i, the rest to dmem words.
    chk({tag, " imem writes"}, 64'(got_iw.size()), 64'(ei));
    for (int i = 0; i < got_iw.size() && i < ei; i++) begin
      chk($sformatf("%s iaddr%0d", tag, i), got_iw[i].a, 64'(4 * i));
      chk($sformatf("%s idata%0d", tag, i), got_iw[i].d, {32'd0, strm[i][31:0]});
    end
    chk({tag, " dmem writes"}, 64'(got_dw.size()), 64'(ed));
    for (int j = 0; j < got_dw.size() && j < ed; j++) begin
      chk($sformatf("%s daddr%0d", tag, j), got_dw[j].a, 64'(8 * j));
      chk($sformatf("%s ddata%0d", tag, j), got_dw[j].d, strm[ei + j]);
    end
    for (int j = 0; j < ed; j++) ref_d[j] = strm[ei + j];
    chk({tag, " enable cycles"}, 64'(n_en), 64'(rc));
    chk({tag, " enable bursts"}, 64'(en_rises), (rc > 0) ? 64'd1 : 64'd0);
    chk({tag, " dump words"}, 64'(got_dump.size()), 64'(ed));
    for (int j = 0; j < got_dump.size() && j < ed; j++)
      chk($sformatf("%s dump%0d", tag, j), got_dump[j], ref_d[j]);
    chk({tag, " done pulses"}, 64'(n_done), 64'd1);
    chk({tag, " protocol"}, 64'(viol), 64'd0);
    if (ei + ed > 0) chk({tag, " start->in_ready"}, 64'(first_rdy), 64'd2);
    if (rc > 0 && ei + ed > 0) chk({tag, " enable after load"}, 64'(first_en), 64'(last_hs + 1));
    if (exp_busy >= 0) chk({tag, " busy cycles"}, 64'(n_busy), 64'(exp_busy));

    idle_busy = 0;
    repeat (3) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      #1;
      if (busy) idle_busy++;
    end
    chk({tag, " idle after done"}, 64'(idle_busy), 64'd0);
  endtask

  typedef struct {
    int il, dl, rc;
    int ei, ed, busy;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int en_seen;
    bit hit;
    int il, dl;

    // Expected write counts and busy cycles: 1 (CLR) + I + D + R + 2D + 1 (DONE).
    vecs[0] = '{3,    2,    5, 3,   2,    16};
    vecs[1] = '{0,    0,    0, 0,   0,    2};
    vecs[2] = '{0,    3,    0, 0,   3,    11};
    vecs[3] = '{4,    0,    2, 4,   0,    8};
    vecs[4] = '{1,    1,    1, 1,   1,    7};
    vecs[5] = '{1000, 0,    0, 512, 0,    514};
    vecs[6] = '{0,    2047, 1, 0,   1024, 3075};
    vecs[7] = '{5,    5,    0, 5,   5,    22};

    arst_n = 1'b0; start = 1'b0; imem_len = '0; dmem_len = '0; run_cycles = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; pf_req = 1'b0; pf_seed = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    chk("reset cpu_enable", 64'(cpu_enable), 64'd0);
    chk("reset strobes", {58'd0, in_ready, out_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 64'd0);
    chk("reset addr_ext", addr_ext, 64'd0);
    chk("reset addr_ext_2", addr_ext_2, 64'd0);
    chk("reset out_data", out_data, 64'd0);
    @(negedge clk);
    arst_n = 1'b1;

    for (int v = 0; v < 8; v++)
      do_run($sformatf("vec%0d", v), vecs[v].il, vecs[v].dl, vecs[v].rc, 0, 0, 1'b0,
             vecs[v].ei, vecs[v].ed, vecs[v].busy);

    // Load with in_valid toggling every other cycle.
    do_run("toggle_valid", 6, 3, 2, 1, 0, 1'b0, 6, 3, -1);
    // Host holds out_ready low for 7 cycles on every dump word.
    do_run("stall_dump", 0, 2, 3, 0, 2, 1'b0, 0, 2, -1);
    // start held high for the whole run, including LOAD_D and DONE.
    do_run("start_spam", 2, 4, 3, 0, 0, 1'b1, 2, 4, 19);

    for (int r = 0; r < 14; r++) begin
      il = $urandom_range(0, 6);
      dl = $urandom_range(0, 6);
      do_run($sformatf("rnd%0d", r), il, dl, $urandom_range(0, 12), 2, 1,
             1'($urandom_range(0, 1)), il, dl, -1);
    end

    // Reset asserted during the 3rd RUN cycle.
    @(negedge clk);
    imem_len = 10'd1; dmem_len = 11'd1; run_cycles = 32'd10;
    in_valid = 1'b1; in_data = 64'h1234_5678_9abc_def0; out_ready = 1'b1;
    start = 1'b1;
    en_seen = 0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (cpu_enable) en_seen++;
      if (en_seen == 3) begin
        arst_n = 1'b0;
        hit = 1'b1;
      end
    end
    chk("rst reached run", 64'(hit), 64'd1);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("rst cpu_enable", 64'(cpu_enable), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("restart clr cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    chk("restart clr busy", 64'(busy), 64'd1);
    @(negedge clk);
    #1;
    chk("restart in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_sequencer.md
# cpu_run_sequencer

Host-side controller that sequences one complete program run on the `cpu` top. It streams a program image into instruction memory and an initial data image into data memory through the external memory ports. It then pulses the CPU reset, raises `enable` for a programmed number of cycles, and streams the data-memory contents back to the host. It sits between the testbench/host link and the `cpu` external ports, and is the only driver of those ports and of `enable`.

## Interface
Parameters:
- `IMEM_WORDS`, 512: instruction-memory depth in 32-bit words.
- `DMEM_WORDS`, 1024: data-memory depth in 64-bit words.

Ports:
- `clk` in 1: clock.
- `arst_n` in 1: reset, synchronous, active-low (name kept per codebase convention).
- `start` in 1: single-cycle request; ignored unless `busy`=0.
- `imem_len` in 10: instruction words to load (0..IMEM_WORDS); sampled on accepted `start`.
- `dmem_len` in 11: data words to load and dump (0..DMEM_WORDS); sampled on accepted `start`.
- `run_cycles` in 32: number of cycles `enable` stays high; sampled on accepted `start`.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 64: load stream. The imem phase uses `in_data[31:0]`.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 64: dump stream.
- `cpu_rst_n` out 1: drives the CPU `arst_n`.
- `cpu_enable` out 1: drives the CPU `enable`.
- `addr_ext` out 64, `wen_ext` out 1, `ren_ext` out 1, `wdata_ext` out 32: instruction-memory external port.
- `addr_ext_2` out 64, `wen_ext_2` out 1, `ren_ext_2` out 1, `wdata_ext_2` out 64, `rdata_ext_2` in 64: data-memory external port.
- `busy` out 1, `done` out 1: status.

## Operation
- States: IDLE, CLR, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_OUT, DONE.
- IDLE, on `start`:
  - Latch the three lengths and clear the word counter `k`.
  - Go to CLR.
- CLR (1 cycle):
  - `cpu_rst_n`=0.
  - Next state is LOAD_I, or LOAD_D if `imem_len`=0.
- LOAD_I:
  - `in_ready`=1.
  - `wen_ext` = `in_valid`; `addr_ext` = 4·k; `wdata_ext` = `in_data[31:0]`. These are combinational, so the write lands on the handshake edge.
  - `k` increments on each handshake.
  - After handshake number `imem_len`, clear `k` and go to LOAD_D (or RUN if `dmem_len`=0).
- LOAD_D:
  - Same as LOAD_I, using `wen_ext_2`, `addr_ext_2` = 8·k, `wdata_ext_2` = `in_data`.
  - Exits to RUN after `dmem_len` handshakes.
- RUN:
  - `cpu_enable`=1 and the cycle counter `c` increments.
  - Leave when `c` = `run_cycles`−1. Go to DUMP_RD with `k`=0, or DONE if `dmem_len`=0.
  - `run_cycles`=0 skips RUN entirely.
- DUMP_RD (1 cycle):
  - `ren_ext_2`=1, `addr_ext_2` = 8·k.
  - Go to DUMP_OUT.
- DUMP_OUT:
  - On entry, `out_data` is registered from `rdata_ext_2`, then held.
  - `out_valid`=1 until `out_ready`.
  - On handshake, `k`++. Go to DUMP_RD, or DONE after word number `dmem_len`.
- DONE (1 cycle): `done`=1, then IDLE.
- `busy`=1 in every state except IDLE.
- All unlisted strobes are 0 in each state; address and data outputs are 0 when their strobe is 0.
- Lengths larger than the depth parameter saturate to that depth.

## Timing
- Reset values: all outputs 0, except `cpu_rst_n`=1. State is IDLE and counters are 0.
- Reset mid-operation: outputs go to reset values on the next edge. Any in-flight stream word is dropped and `cpu_enable` falls immediately.
- `start` to first `in_ready`: 2 cycles (CLR in between).
- `cpu_enable` is high for exactly `run_cycles` consecutive cycles. It rises on the edge after the final load handshake.
- Dump throughput: at most 1 word per 2 cycles. With `out_ready` held high, dumping N words takes 2N cycles.
- `start` asserted while `busy`=1 has no effect. `start` in the DONE cycle is also ignored.
- The instruction-memory and data-memory strobes are never high in the same cycle.

## Structure
- Shared package `cpu_seq_pkg`: the state enum and the byte strides (4 and 8).
- One natural sub-module: `seq_counter`, a loadable, clearable up-counter with a terminal-count compare. Instantiate it twice: `k` is 11 bits, `c` is 32 bits.
- The FSM and output decode stay in the top module.

## Test plan
- `imem_len`=3, `dmem_len`=2, `run_cycles`=5, stream words A..E:
  - `wen_ext` at addresses 0, 4, 8 with A..C; `wen_ext_2` at addresses 0, 8 with D, E.
  - `cpu_enable` high for 5 cycles.
  - Dump returns the memory model's 2 words; `done` pulses once.
- Load with `in_valid` toggling every other cycle: exactly `imem_len` writes occur, and no write happens while `in_valid`=0.
- Dump with `out_ready` held low for 7 cycles: `out_data` is stable, `ren_ext_2` is not re-asserted, and the word is accepted when `out_ready` rises.
- `imem_len`=0, `dmem_len`=0, `run_cycles`=0: sequence is IDLE→CLR→DONE→IDLE. `busy` is high for 2 cycles and `cpu_enable` never rises.
- `arst_n` low in the 3rd RUN cycle: next edge shows `cpu_enable`=0 and `busy`=0. A new `start` then begins from CLR.
- Second `start` pulse during LOAD_D: no effect, and the counters keep progressing.
